lfsr_operand_gen: RTL and testbench

- Hardware pseudo-random operand source for built-in self-test of the arithmetic utilities: adders, comparators, shifters.
- Sits directly upstream of the unit under test. Replaces software random stimulus with a Galois LFSR.
- Issues a programmed number of operand pairs (a, b) over a valid/ready handshake.
- Optionally compacts the unit's responses into a signature.

---
 rtl/lfsr_operand_gen.sv | 146 ++++++++++++++
 tb/tb_lfsr_operand_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_operand_gen.sv
// Galois-LFSR operand pair source for arithmetic-unit self-test, valid/ready output.
// Define LFSR_OPERAND_GEN_MISR_EN to add response compaction (resp_i -> signature_o).
module lfsr_operand_gen #(
  parameter int unsigned                 WORD_WIDTH  = 8,
  parameter int unsigned                 COUNT_WIDTH = 16,
  parameter logic [2*WORD_WIDTH-1:0]     POLY        = 16'hB400
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [COUNT_WIDTH-1:0]   count,
  input  logic [2*WORD_WIDTH-1:0]  seed,
  output logic [WORD_WIDTH-1:0]    a_o,
  output logic [WORD_WIDTH-1:0]    b_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [COUNT_WIDTH-1:0]   issued_o
`ifdef LFSR_OPERAND_GEN_MISR_EN
  ,
  input  logic [WORD_WIDTH-1:0]    resp_i,
  output logic [2*WORD_WIDTH-1:0]  signature_o
`endif
);

  localparam int unsigned LW = 2 * WORD_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One Galois shift-right step; shared by the operand LFSR and the MISR.
  function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  state_e                 state_q, state_d;
  logic [LW-1:0]          lfsr_q, lfsr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] issued_q, issued_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   handshake_c;
`ifdef LFSR_OPERAND_GEN_MISR_EN
  logic [LW-1:0]          sig_q, sig_d;
`endif

  assign handshake_c = valid_q & ready_i;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    remaining_d = remaining_q;
    issued_d    = issued_q;
    valid_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
`ifdef LFSR_OPERAND_GEN_MISR_EN
    sig_d       = sig_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          issued_d = '0;
`ifdef LFSR_OPERAND_GEN_MISR_EN
          sig_d    = '0;
`endif
          if (count != '0) begin
            // An all-zero seed would lock the LFSR, so substitute 1.
            lfsr_d      = (seed == '0) ? LW'(1) : seed;
            remaining_d = count;
            state_d     = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (handshake_c) begin
          lfsr_d      = lfsr_step(lfsr_q);
          remaining_d = remaining_q - COUNT_WIDTH'(1);
          issued_d    = issued_q + COUNT_WIDTH'(1);
`ifdef LFSR_OPERAND_GEN_MISR_EN
          sig_d       = lfsr_step(sig_q) ^ LW'(resp_i);
`endif
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags track the upcoming state so they change on the same edge.
    valid_d = (state_d == S_RUN);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= '0;
      remaining_q <= '0;
      issued_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LFSR_OPERAND_GEN_MISR_EN
      sig_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      remaining_q <= remaining_d;
      issued_q    <= issued_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef LFSR_OPERAND_GEN_MISR_EN
      sig_q       <= sig_d;
`endif
    end
  end

  assign a_o      = lfsr_q[LW-1:WORD_WIDTH];
  assign b_o      = lfsr_q[WORD_WIDTH-1:0];
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign issued_o = issued_q;
`ifdef LFSR_OPERAND_GEN_MISR_EN
  assign signature_o = sig_q;
`endif

endmodule

// File: tb/tb_lfsr_operand_gen.sv
// Directed bench for lfsr_operand_gen; MISR checks compile in with LFSR_OPERAND_GEN_MISR_EN.
module tb_lfsr_operand_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] count = '0;
  logic [15:0] seed = '0;
  logic        ready_i = 1'b0;
  logic [7:0]  a_o, b_o;
  logic        valid_o, busy_o, done_o;
  logic [15:0] issued_o;
`ifdef LFSR_OPERAND_GEN_MISR_EN
  logic [7:0]  resp_i = '0;
  logic [15:0] signature_o;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  lfsr_operand_gen dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .count    (count),
    .seed     (seed),
    .a_o      (a_o),
    .b_o      (b_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .issued_o (issued_o)
`ifdef LFSR_OPERAND_GEN_MISR_EN
    ,
    .resp_i      (resp_i),
    .signature_o (signature_o)
`endif
  );

  // Hand-computed pairs {a,b} for seed 0x0001 with POLY 0xB400.
  function automatic logic [15:0] exp_pair(input int i);
    case (i)
      0:       return 16'h0001;
      1:       return 16'hB400;
      2:       return 16'h5A00;
      3:       return 16'h2D00;
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    vectors++;
    if ({a_o, b_o, valid_o, busy_o, done_o} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h b=%h v=%b busy=%b d=%b, want all 0",
               a_o, b_o, valid_o, busy_o, done_o);
    end
    vectors++;
    if (issued_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_issued: got %0d want 0", issued_o);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    ready_i = 1'b1; seed = 16'h0001; count = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({a_o, b_o, valid_o, busy_o, done_o} !== {exp_pair(i), 3'b110}) begin
        errors++;
        $display("FAIL basic_pair%0d: got %h%h v=%b busy=%b d=%b, want %h v=1 busy=1 d=0",
                 i, a_o, b_o, valid_o, busy_o, done_o, exp_pair(i));
      end
      tick();
    end
    vectors++;
    if ({valid_o, busy_o, done_o, issued_o} !== {3'b001, 16'd4}) begin
      errors++;
      $display("FAIL basic_done: got v=%b busy=%b d=%b issued=%0d, want v=0 busy=0 d=1 issued=4",
               valid_o, busy_o, done_o, issued_o);
    end
    tick();
    vectors++;
    if ({valid_o, done_o, issued_o} !== {2'b00, 16'd4}) begin
      errors++;
      $display("FAIL basic_after_done: got v=%b d=%b issued=%0d, want v=0 d=0 issued=4",
               valid_o, done_o, issued_o);
    end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0; seed = 16'h0001; count = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({a_o, b_o, valid_o, issued_o} !== {16'h0001, 1'b1, 16'd0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h%h v=%b issued=%0d, want 0001 v=1 issued=0",
                 k, a_o, b_o, valid_o, issued_o);
      end
      if (k < 3) tick();
    end
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({a_o, b_o, valid_o, done_o} !== {exp_pair(i), 2'b10}) begin
        errors++;
        $display("FAIL bp_pair%0d: got %h%h v=%b d=%b, want %h v=1 d=0",
                 i, a_o, b_o, valid_o, done_o, exp_pair(i));
      end
      tick();
    end
    vectors++;
    if ({valid_o, done_o, issued_o} !== {2'b01, 16'd4}) begin
      errors++;
      $display("FAIL bp_done: got v=%b d=%b issued=%0d, want v=0 d=1 issued=4",
               valid_o, done_o, issued_o);
    end
    tick();
  endtask

  task automatic test_degenerate();
    ready_i = 1'b1; seed = 16'h0000; count = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({a_o, b_o, valid_o} !== {exp_pair(i), 1'b1}) begin
        errors++;
        $display("FAIL seed0_pair%0d: got %h%h v=%b, want %h v=1",
                 i, a_o, b_o, valid_o, exp_pair(i));
      end
      tick();
    end
    vectors++;
    if ({done_o, issued_o} !== {1'b1, 16'd2}) begin
      errors++;
      $display("FAIL seed0_done: got d=%b issued=%0d, want d=1 issued=2", done_o, issued_o);
    end
    tick();
    count = 16'd0; seed = 16'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({valid_o, busy_o, done_o, issued_o} !== {3'b001, 16'd0}) begin
      errors++;
      $display("FAIL count0_done: got v=%b busy=%b d=%b issued=%0d, want v=0 busy=0 d=1 issued=0",
               valid_o, busy_o, done_o, issued_o);
    end
    tick();
    vectors++;
    if ({valid_o, done_o} !== 2'b00) begin
      errors++;
      $display("FAIL count0_after: got v=%b d=%b, want v=0 d=0", valid_o, done_o);
    end
  endtask

  task automatic test_start_during_run();
    ready_i = 1'b1; seed = 16'h0001; count = 16'd4; start = 1'b1;
    tick();
    seed = 16'h1234; count = 16'd9;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({a_o, b_o, valid_o} !== {exp_pair(i), 1'b1}) begin
        errors++;
        $display("FAIL restart_ignored_pair%0d: got %h%h v=%b, want %h v=1",
                 i, a_o, b_o, valid_o, exp_pair(i));
      end
      if (i == 1) start = 1'b0;
      tick();
    end
    vectors++;
    if ({done_o, issued_o} !== {1'b1, 16'd4}) begin
      errors++;
      $display("FAIL restart_ignored_done: got d=%b issued=%0d, want d=1 issued=4",
               done_o, issued_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    ready_i = 1'b1; seed = 16'h0001; count = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({a_o, b_o, valid_o, busy_o, done_o, issued_o} !== 35'h0) begin
      errors++;
      $display("FAIL reset_async: got a=%h b=%h v=%b busy=%b d=%b issued=%0d, want all 0",
               a_o, b_o, valid_o, busy_o, done_o, issued_o);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({a_o, b_o, valid_o} !== {exp_pair(i), 1'b1}) begin
        errors++;
        $display("FAIL reset_rerun_pair%0d: got %h%h v=%b, want %h v=1",
                 i, a_o, b_o, valid_o, exp_pair(i));
      end
      tick();
    end
    vectors++;
    if ({done_o, issued_o} !== {1'b1, 16'd4}) begin
      errors++;
      $display("FAIL reset_rerun_done: got d=%b issued=%0d, want d=1 issued=4", done_o, issued_o);
    end
    tick();
  endtask

`ifdef LFSR_OPERAND_GEN_MISR_EN
  task automatic test_misr();
    for (int rep = 0; rep < 2; rep++) begin
      ready_i = 1'b1; seed = 16'h0001; count = 16'd2; resp_i = 8'h01; start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (signature_o !== 16'h0000) begin
        errors++;
        $display("FAIL misr_clear%0d: got %h want 0000", rep, signature_o);
      end
      tick();
      vectors++;
      if (signature_o !== 16'h0001) begin
        errors++;
        $display("FAIL misr_first%0d: got %h want 0001", rep, signature_o);
      end
      resp_i = 8'h02;
      tick();
      vectors++;
      if ({done_o, signature_o} !== {1'b1, 16'hB402}) begin
        errors++;
        $display("FAIL misr_final%0d: got d=%b sig=%h, want d=1 sig=b402", rep, done_o, signature_o);
      end
      resp_i = 8'hFF;
      tick();
      vectors++;
      if (signature_o !== 16'hB402) begin
        errors++;
        $display("FAIL misr_stable%0d: got %h want b402", rep, signature_o);
      end
    end
    resp_i = 8'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_degenerate();
    test_start_during_run();
    test_reset_mid_run();
`ifdef LFSR_OPERAND_GEN_MISR_EN
    test_misr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
